// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - SAP control-word bit map, opcodes and microcode tables
package sap_ctrl_pkg;

    localparam int CB_PC_OUT  = 0;
    localparam int CB_MAR_IN  = 1;
    localparam int CB_PC_INC  = 2;
    localparam int CB_RAM_OUT = 3;
    localparam int CB_IR_IN   = 4;
    localparam int CB_IR_OUT  = 5;
    localparam int CB_A_IN    = 6;
    localparam int CB_A_OUT   = 7;
    localparam int CB_ALU_SUB = 8;
    localparam int CB_ALU_OUT = 9;
    localparam int CB_B_IN    = 10;
    localparam int CB_OUT_IN  = 11;
    localparam int CB_PC_LOAD = 12;
    localparam int CB_RAM_IN  = 13;
    localparam int CB_HLT     = 14;

    localparam logic [15:0] M_PC_OUT  = 16'h0001 << CB_PC_OUT;
    localparam logic [15:0] M_MAR_IN  = 16'h0001 << CB_MAR_IN;
    localparam logic [15:0] M_PC_INC  = 16'h0001 << CB_PC_INC;
    localparam logic [15:0] M_RAM_OUT = 16'h0001 << CB_RAM_OUT;
    localparam logic [15:0] M_IR_IN   = 16'h0001 << CB_IR_IN;
    localparam logic [15:0] M_IR_OUT  = 16'h0001 << CB_IR_OUT;
    localparam logic [15:0] M_A_IN    = 16'h0001 << CB_A_IN;
    localparam logic [15:0] M_A_OUT   = 16'h0001 << CB_A_OUT;
    localparam logic [15:0] M_ALU_SUB = 16'h0001 << CB_ALU_SUB;
    localparam logic [15:0] M_ALU_OUT = 16'h0001 << CB_ALU_OUT;
    localparam logic [15:0] M_B_IN    = 16'h0001 << CB_B_IN;
    localparam logic [15:0] M_OUT_IN  = 16'h0001 << CB_OUT_IN;
    localparam logic [15:0] M_PC_LOAD = 16'h0001 << CB_PC_LOAD;
    localparam logic [15:0] M_RAM_IN  = 16'h0001 << CB_RAM_IN;
    localparam logic [15:0] M_HLT     = 16'h0001 << CB_HLT;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [15:0] FETCH_T0 = M_PC_OUT | M_MAR_IN;
    localparam logic [15:0] FETCH_T1 = M_PC_INC;
    localparam logic [15:0] FETCH_T2 = M_RAM_OUT | M_IR_IN;

    // Steps not named for an opcode, including EARLY_END=0 padding, produce 0.
    function automatic logic [15:0] microcode_word(input logic [3:0] op, input logic [4:0] step,
                                                   input logic fc, input logic fz);
        logic [15:0] w;
        w = '0;
        case (step)
            5'd0: w = FETCH_T0;
            5'd1: w = FETCH_T1;
            5'd2: w = FETCH_T2;
            5'd3: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = M_IR_OUT | M_MAR_IN;
                    OP_LDI:  w = M_IR_OUT | M_A_IN;
                    OP_JMP:  w = M_IR_OUT | M_PC_LOAD;
                    OP_JC:   w = fc ? (M_IR_OUT | M_PC_LOAD) : '0;
                    OP_JZ:   w = fz ? (M_IR_OUT | M_PC_LOAD) : '0;
                    OP_OUT:  w = M_A_OUT | M_OUT_IN;
                    OP_HLT:  w = M_HLT;
                    default: w = '0;
                endcase
            end
            5'd4: begin
                case (op)
                    OP_LDA:  w = M_RAM_OUT | M_A_IN;
                    OP_ADD:  w = M_RAM_OUT | M_B_IN;
                    OP_SUB:  w = M_RAM_OUT | M_B_IN | M_ALU_SUB;
                    OP_STA:  w = M_A_OUT | M_RAM_IN;
                    default: w = '0;
                endcase
            end
            5'd5: begin
                case (op)
                    OP_ADD:  w = M_ALU_OUT | M_A_IN;
                    OP_SUB:  w = M_ALU_OUT | M_A_IN | M_ALU_SUB;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [4:0] last_step(input logic [3:0] op);
        logic [4:0] s;
        case (op)
            OP_LDA, OP_STA:                         s = 5'd4;
            OP_ADD, OP_SUB:                         s = 5'd5;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                 s = 5'd3;
            default:                                s = 5'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - one-hot ring counter with enable and synchronous return to T0
module sap_ring_counter #(
    parameter int LEN = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           load_i,
    output logic [LEN-1:0] ring_o
);

    logic [LEN-1:0] ring_q;
    logic [LEN-1:0] ring_d;

    always_comb begin
        ring_d = ring_q;
        if (load_i) begin
            ring_d = LEN'(1);
        end else if (en_i) begin
            ring_d = {ring_q[LEN-2:0], ring_q[LEN-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= LEN'(1);
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - T-state sequencer and microcode decoder driving the SAP control word
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int TSTATES   = 6,
    parameter int CTRL_W    = 16,
    parameter bit EARLY_END = 1'b1,
    parameter int COUNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_en,
    input  logic                resume,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_c,
    input  logic                flag_z,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [TSTATES-1:0]  tstate,
    output logic                halted,
    output logic                instr_retired,
    output logic [COUNT_W-1:0]  instr_count
);

    logic [TSTATES-1:0] ring;
    logic [4:0]         step_idx;
    logic [3:0]         op4;
    logic               at_last;
    logic               hlt_step;
    logic               ring_en;
    logic               ring_load;
    logic               halted_q, halted_d;
    logic               retired_q, retired_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [15:0]        word;

    assign op4 = 4'(opcode);

    sap_ring_counter #(.LEN(TSTATES)) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (ring_en),
        .load_i (ring_load),
        .ring_o (ring)
    );

    always_comb begin
        step_idx = '0;
        for (int i = 0; i < TSTATES; i++) begin
            if (ring[i]) step_idx = 5'(i);
        end
    end

    // The last-step decision at T2 (NOP) reads the opcode directly; the IR must hold it stable.
    assign at_last  = (EARLY_END && (step_idx == last_step(op4))) || (step_idx == 5'(TSTATES - 1));
    assign hlt_step = (op4 == OP_HLT) && (step_idx == 5'd3);

    always_comb begin
        ring_en   = 1'b0;
        ring_load = 1'b0;
        halted_d  = halted_q;
        retired_d = 1'b0;
        count_d   = count_q;
        if (step_en) begin
            if (halted_q) begin
                if (resume) begin
                    halted_d  = 1'b0;
                    ring_load = 1'b1;
                end
            end else if (hlt_step) begin
                halted_d  = 1'b1;
                retired_d = 1'b1;
                count_d   = count_q + COUNT_W'(1);
            end else if (at_last) begin
                ring_load = 1'b1;
                retired_d = 1'b1;
                count_d   = count_q + COUNT_W'(1);
            end else begin
                ring_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            retired_q <= 1'b0;
            count_q   <= '0;
        end else begin
            halted_q  <= halted_d;
            retired_q <= retired_d;
            count_q   <= count_d;
        end
    end

    assign word = halted_q ? M_HLT : microcode_word(op4, step_idx, flag_c, flag_z);

    assign ctrl          = rst_n ? CTRL_W'(word) : '0;
    assign tstate        = ring;
    assign halted        = halted_q;
    assign instr_retired = retired_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - scoreboard bench for two sequencer configurations
module tb_sap_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, step_en, resume;
    logic [3:0] op_a, op_b;
    logic       fc_a, fz_a, fc_b, fz_b;

    logic [15:0] ctrl_a;
    logic [5:0]  ts_a;
    logic        halted_a, ret_a;
    logic [7:0]  cnt_a;
    logic [19:0] ctrl_b;
    logic [7:0]  ts_b;
    logic        halted_b, ret_b;
    logic [7:0]  cnt_b;

    sap_control_sequencer #(.OPCODE_W(4), .TSTATES(6), .CTRL_W(16), .EARLY_END(1'b1), .COUNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .resume(resume), .opcode(op_a),
        .flag_c(fc_a), .flag_z(fz_a), .ctrl(ctrl_a), .tstate(ts_a), .halted(halted_a),
        .instr_retired(ret_a), .instr_count(cnt_a));

    sap_control_sequencer #(.OPCODE_W(4), .TSTATES(8), .CTRL_W(20), .EARLY_END(1'b0), .COUNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .resume(resume), .opcode(op_b),
        .flag_c(fc_b), .flag_z(fz_b), .ctrl(ctrl_b), .tstate(ts_b), .halted(halted_b),
        .instr_retired(ret_b), .instr_count(cnt_b));

    typedef struct packed {
        logic [19:0] ctrl;
        logic [15:0] ts;
        logic        halted;
        logic        ret;
        logic [7:0]  cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] ex [0:15][0:2];
    int          lastst [0:15];

    int sa, sb, ca, cb;
    bit ha, hb;
    bit stepped = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int op, input int s, input bit fc, input bit fz, input bit h);
        logic [15:0] w;
        if (h) return 16'h4000;
        if (s == 0) return 16'h0003;
        if (s == 1) return 16'h0004;
        if (s == 2) return 16'h0018;
        if (s > 5) return 16'h0000;
        w = ex[op][s-3];
        if ((op == 7 && !fc) || (op == 8 && !fz)) w = 16'h0000;
        return w;
    endfunction

    task automatic model_step(input int T, input bit ee, input int op, input bit res,
                              input int s_in, input bit h_in, input int c_in,
                              output int s, output bit h, output int c, output bit ret);
        s = s_in; h = h_in; c = c_in; ret = 1'b0;
        if (h) begin
            if (res) begin h = 1'b0; s = 0; end
        end else if (op == 15 && s == 3) begin
            h = 1'b1; c = (c + 1) % 256; ret = 1'b1;
        end else if ((ee && s == lastst[op]) || s == T - 1) begin
            s = 0; c = (c + 1) % 256; ret = 1'b1;
        end else begin
            s = s + 1;
        end
    endtask

    task automatic step(input bit res, input bit rand_a);
        exp_t e;
        bit   r;
        @(posedge clk); #1;
        if (rand_a && sa == 0 && !ha) begin
            op_a = 4'($urandom_range(0, 15)); fc_a = 1'($urandom); fz_a = 1'($urandom);
        end
        if (sb == 0 && !hb) begin
            op_b = 4'($urandom_range(0, 15)); fc_b = 1'($urandom); fz_b = 1'($urandom);
        end
        resume  = res;
        step_en = 1'b1;
        model_step(6, 1'b1, int'(op_a), res, sa, ha, ca, sa, ha, ca, r);
        e.ctrl = 20'(exp_word(int'(op_a), sa, fc_a, fz_a, ha));
        e.ts = 16'(1 << sa); e.halted = ha; e.ret = r; e.cnt = 8'(ca);
        qa.push_back(e);
        model_step(8, 1'b0, int'(op_b), res, sb, hb, cb, sb, hb, cb, r);
        e.ctrl = 20'(exp_word(int'(op_b), sb, fc_b, fz_b, hb));
        e.ts = 16'(1 << sb); e.halted = hb; e.ret = r; e.cnt = 8'(cb);
        qb.push_back(e);
        @(posedge clk); #1;
        step_en = 1'b0;
        resume  = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl_a"}, 32'(ctrl_a), 32'h0);
        check({tag, "_ts_a"}, 32'(ts_a), 32'h1);
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'h0);
        check({tag, "_halt_a"}, 32'(halted_a), 32'h0);
        check({tag, "_ret_a"}, 32'(ret_a), 32'h0);
        check({tag, "_ctrl_b"}, 32'(ctrl_b), 32'h0);
        check({tag, "_ts_b"}, 32'(ts_b), 32'h1);
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state(tag);
        sa = 0; sb = 0; ca = 0; cb = 0; ha = 1'b0; hb = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check({tag, "_post_ctrl_a"}, 32'(ctrl_a), 32'h0003);
        check({tag, "_post_cnt_a"}, 32'(cnt_a), 32'h0);
        check({tag, "_post_ts_a"}, 32'(ts_a), 32'h1);
    endtask

    always @(posedge clk) stepped <= step_en & rst_n;

    always @(negedge clk) begin
        exp_t e;
        if (stepped) begin
            if (qa.size() == 0) begin
                check("qa_underflow", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_ctrl", 32'(ctrl_a), 32'(e.ctrl));
                check("a_tstate", 32'(ts_a), 32'(e.ts));
                check("a_halted", 32'(halted_a), 32'(e.halted));
                check("a_retired", 32'(ret_a), 32'(e.ret));
                check("a_count", 32'(cnt_a), 32'(e.cnt));
            end
            if (qb.size() == 0) begin
                check("qb_underflow", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_ctrl", 32'(ctrl_b), 32'(e.ctrl));
                check("b_tstate", 32'(ts_b), 32'(e.ts));
                check("b_halted", 32'(halted_b), 32'(e.halted));
                check("b_retired", 32'(ret_b), 32'(e.ret));
                check("b_count", 32'(cnt_b), 32'(e.cnt));
            end
        end
    end

    initial begin
        for (int o = 0; o < 16; o++) begin
            ex[o][0] = 16'h0; ex[o][1] = 16'h0; ex[o][2] = 16'h0;
            lastst[o] = 2;
        end
        ex[1][0] = 16'h0022; ex[1][1] = 16'h0048;                        lastst[1] = 4;
        ex[2][0] = 16'h0022; ex[2][1] = 16'h0408; ex[2][2] = 16'h0240;   lastst[2] = 5;
        ex[3][0] = 16'h0022; ex[3][1] = 16'h0508; ex[3][2] = 16'h0340;   lastst[3] = 5;
        ex[4][0] = 16'h0022; ex[4][1] = 16'h2080;                        lastst[4] = 4;
        ex[5][0] = 16'h0060;                                             lastst[5] = 3;
        ex[6][0] = 16'h1020;                                             lastst[6] = 3;
        ex[7][0] = 16'h1020;                                             lastst[7] = 3;
        ex[8][0] = 16'h1020;                                             lastst[8] = 3;
        ex[14][0] = 16'h0880;                                            lastst[14] = 3;
        ex[15][0] = 16'h4000;                                            lastst[15] = 3;

        rst_n = 1'b1; step_en = 1'b0; resume = 1'b0;
        op_a = 4'h2; op_b = 4'h0; fc_a = 1'b0; fz_a = 1'b0; fc_b = 1'b0; fz_b = 1'b0;
        do_reset("reset");

        op_a = 4'h2;
        repeat (6) step(1'b0, 1'b0);
        check("add_count", 32'(cnt_a), 32'd1);

        op_a = 4'h7; fc_a = 1'b0;
        repeat (4) step(1'b0, 1'b0);
        fc_a = 1'b1;
        repeat (4) step(1'b0, 1'b0);
        op_a = 4'h8; fz_a = 1'b1;
        repeat (4) step(1'b0, 1'b0);

        op_a = 4'hF;
        repeat (4) step(1'b0, 1'b0);
        check("hlt_halted", 32'(halted_a), 32'd1);
        repeat (10) step(1'b0, 1'b0);
        check("hlt_hold_ts", 32'(ts_a), 32'h08);
        step(1'b1, 1'b0);
        check("resume_ts", 32'(ts_a), 32'h01);

        op_a = 4'h1;
        repeat (4) step(1'b0, 1'b0);
        check("lda_t4_ts", 32'(ts_a), 32'h10);
        do_reset("midreset");

        op_a = 4'h0;
        repeat (256 * 3) step(1'b0, 1'b0);
        check("nop_wrap", 32'(cnt_a), 32'd0);

        repeat (1500) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            step(($urandom_range(0, 3) == 0), 1'b1);
        end

        repeat (3) @(negedge clk);
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
